// File: rtl/secp256k1_mult_arb.sv
// Round-robin arbiter that lets several point-arithmetic sequencers share one modular multiplier.
// Requests are tagged with the client index above the client ctl; results are routed back by that tag.
module secp256k1_mult_arb #(
   parameter int NUM_IN   = 2,
   parameter int CTL_BITS = 8,
   parameter int IDX_BITS = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [NUM_IN*512-1:0]        i_req_dat,
   input  logic [NUM_IN*CTL_BITS-1:0]   i_req_ctl,
   input  logic [NUM_IN-1:0]            i_req_err,
   input  logic [NUM_IN-1:0]            i_req_val,
   output logic [NUM_IN-1:0]            o_req_rdy,
   output logic [511:0]                 o_mul_dat,
   output logic [CTL_BITS+IDX_BITS-1:0] o_mul_ctl,
   output logic                         o_mul_err,
   output logic                         o_mul_val,
   input  logic                         i_mul_rdy,
   input  logic [255:0]                 i_res_dat,
   input  logic [CTL_BITS+IDX_BITS-1:0] i_res_ctl,
   input  logic                         i_res_err,
   input  logic                         i_res_val,
   output logic                         o_res_rdy,
   output logic [255:0]                 o_res_dat,
   output logic [CTL_BITS-1:0]          o_res_ctl,
   output logic                         o_res_err,
   output logic [NUM_IN-1:0]            o_res_val,
   input  logic [NUM_IN-1:0]            i_res_rdy,
   output logic                         o_err
);

   logic [IDX_BITS-1:0]          rr_q, rr_d;
   logic [IDX_BITS-1:0]          gnt_idx;
   logic                         gnt_vld;
   logic [511:0]                 gnt_dat;
   logic [CTL_BITS-1:0]          gnt_ctl;
   logic                         gnt_err;
   logic                         load;
   logic [IDX_BITS-1:0]          res_tag;
   logic                         tag_ok;
   logic [511:0]                 mul_dat_q;
   logic [CTL_BITS+IDX_BITS-1:0] mul_ctl_q;
   logic                         mul_err_q;
   logic                         mul_val_q;
   logic                         err_q;

   assign load = !mul_val_q || i_mul_rdy;

   // First requester at or after rr, wrapping back to client 0
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         logic [IDX_BITS-1:0] cand;
         int                  j;
         j = int'(rr_q) + k;
         if (j >= NUM_IN) j = j - NUM_IN;
         cand = IDX_BITS'(j);
         if (!gnt_vld && i_req_val[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
      gnt_dat = i_req_dat[int'(gnt_idx)*512 +: 512];
      gnt_ctl = i_req_ctl[int'(gnt_idx)*CTL_BITS +: CTL_BITS];
      gnt_err = i_req_err[gnt_idx];
      rr_d    = (gnt_idx == IDX_BITS'(NUM_IN-1)) ? '0 : gnt_idx + IDX_BITS'(1);
   end

   assign o_req_rdy = (i_rst && load && gnt_vld) ? (NUM_IN'(1) << gnt_idx) : '0;

   assign res_tag = i_res_ctl[CTL_BITS +: IDX_BITS];
   assign tag_ok  = int'(res_tag) < NUM_IN;

   always_comb begin
      o_res_val = '0;
      o_res_rdy = 1'b0;
      if (i_rst) begin
         if (tag_ok) begin
            o_res_val = i_res_val ? (NUM_IN'(1) << res_tag) : '0;
            o_res_rdy = i_res_rdy[res_tag];
         end else begin
            o_res_rdy = 1'b1;
         end
      end
   end

   assign o_res_dat = i_res_dat;
   assign o_res_ctl = i_res_ctl[CTL_BITS-1:0];
   assign o_res_err = i_res_err;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         mul_dat_q <= '0;
         mul_ctl_q <= '0;
         mul_err_q <= 1'b0;
         mul_val_q <= 1'b0;
         rr_q      <= '0;
         err_q     <= 1'b0;
      end else begin
         if (load) begin
            if (gnt_vld) begin
               mul_dat_q <= gnt_dat;
               mul_ctl_q <= {gnt_idx, gnt_ctl};
               mul_err_q <= gnt_err;
               mul_val_q <= 1'b1;
               rr_q      <= rr_d;
            end else begin
               mul_val_q <= 1'b0;
            end
         end
         // Results with an out-of-range tag are swallowed and flagged until reset
         if (i_res_val && !tag_ok) err_q <= 1'b1;
      end
   end

   assign o_mul_dat = mul_dat_q;
   assign o_mul_ctl = mul_ctl_q;
   assign o_mul_err = mul_err_q;
   assign o_mul_val = mul_val_q;
   assign o_err     = err_q;

endmodule

// File: tb/tb_secp256k1_mult_arb.sv
// Directed bench for secp256k1_mult_arb with three clients: reset, fairness, stall, routing, bad tag.
module tb_secp256k1_mult_arb;

   localparam int NUM_IN   = 3;
   localparam int CTL_BITS = 8;
   localparam int IDX_BITS = 2;
   localparam int CW       = CTL_BITS + IDX_BITS;

   logic                       i_clk = 1'b0;
   logic                       i_rst;
   logic [NUM_IN*512-1:0]      i_req_dat;
   logic [NUM_IN*CTL_BITS-1:0] i_req_ctl;
   logic [NUM_IN-1:0]          i_req_err;
   logic [NUM_IN-1:0]          i_req_val;
   logic [NUM_IN-1:0]          o_req_rdy;
   logic [511:0]               o_mul_dat;
   logic [CW-1:0]              o_mul_ctl;
   logic                       o_mul_err;
   logic                       o_mul_val;
   logic                       i_mul_rdy;
   logic [255:0]               i_res_dat;
   logic [CW-1:0]              i_res_ctl;
   logic                       i_res_err;
   logic                       i_res_val;
   logic                       o_res_rdy;
   logic [255:0]               o_res_dat;
   logic [CTL_BITS-1:0]        o_res_ctl;
   logic                       o_res_err;
   logic [NUM_IN-1:0]          o_res_val;
   logic [NUM_IN-1:0]          i_res_rdy;
   logic                       o_err;

   int checks = 0;
   int errors = 0;

   always #5 i_clk = ~i_clk;

   secp256k1_mult_arb #(.NUM_IN(NUM_IN), .CTL_BITS(CTL_BITS), .IDX_BITS(IDX_BITS)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_req_dat(i_req_dat), .i_req_ctl(i_req_ctl), .i_req_err(i_req_err),
      .i_req_val(i_req_val), .o_req_rdy(o_req_rdy),
      .o_mul_dat(o_mul_dat), .o_mul_ctl(o_mul_ctl), .o_mul_err(o_mul_err),
      .o_mul_val(o_mul_val), .i_mul_rdy(i_mul_rdy),
      .i_res_dat(i_res_dat), .i_res_ctl(i_res_ctl), .i_res_err(i_res_err),
      .i_res_val(i_res_val), .o_res_rdy(o_res_rdy),
      .o_res_dat(o_res_dat), .o_res_ctl(o_res_ctl), .o_res_err(o_res_err),
      .o_res_val(o_res_val), .i_res_rdy(i_res_rdy), .o_err(o_err)
   );

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one edge, then let inputs settle away from it
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_client(input int c, input logic [255:0] a, input logic [255:0] b,
                             input logic [7:0] ctl, input logic err);
      i_req_dat[c*512 +: 512] = {b, a};
      i_req_ctl[c*8 +: 8]     = ctl;
      i_req_err[c]            = err;
   endtask

   initial begin
      i_rst     = 1'b0;
      i_req_dat = '0;
      i_req_ctl = '0;
      i_req_err = '0;
      i_req_val = 3'b111;
      i_mul_rdy = 1'b1;
      i_res_dat = 256'd6;
      i_res_ctl = {2'd0, 8'h11};
      i_res_err = 1'b0;
      i_res_val = 1'b1;
      i_res_rdy = 3'b111;
      for (int c = 0; c < NUM_IN; c++) set_client(c, 256'(c + 1), 256'(c + 100), 8'(8'h10 + c), 1'(c == 1));

      // Reset held with everything active
      repeat (3) tick();
      chk("rst_mul_val", 512'(o_mul_val), 512'd0);
      chk("rst_mul_ctl", 512'(o_mul_ctl), 512'd0);
      chk("rst_mul_dat", o_mul_dat, 512'd0);
      chk("rst_req_rdy", 512'(o_req_rdy), 512'd0);
      chk("rst_res_rdy", 512'(o_res_rdy), 512'd0);
      chk("rst_res_val", 512'(o_res_val), 512'd0);
      chk("rst_err", 512'(o_err), 512'd0);
      i_res_val = 1'b0;

      // Fairness: tags 0,1,2,0,1,2 back to back
      i_rst = 1'b1;
      #1;
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("rr_rdy%0d", k), 512'(o_req_rdy), 512'(3'b001 << (k % 3)));
         tick();
         chk($sformatf("rr_ctl%0d", k), 512'(o_mul_ctl), 512'({2'(k % 3), 8'(8'h10 + k % 3)}));
         chk($sformatf("rr_val%0d", k), 512'(o_mul_val), 512'd1);
      end
      chk("rr_dat", o_mul_dat, {256'd102, 256'd3});
      chk("rr_err1", 512'(o_mul_err), 512'd0);

      // Backpressure: load client 1 then stall for 4 cycles
      set_client(1, 256'd5, 256'd7, 8'h3C, 1'b1);
      set_client(0, 256'd2, 256'd3, 8'hA5, 1'b0);
      i_req_val = 3'b010;
      #1;
      chk("bp_rdy_load", 512'(o_req_rdy), 512'b010);
      tick();
      i_req_val = 3'b011;
      i_mul_rdy = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("bp_rdy%0d", k), 512'(o_req_rdy), 512'd0);
         chk($sformatf("bp_dat%0d", k), o_mul_dat, {256'd7, 256'd5});
         chk($sformatf("bp_ctl%0d", k), 512'(o_mul_ctl), 512'({2'd1, 8'h3C}));
         chk($sformatf("bp_val%0d", k), 512'(o_mul_val), 512'd1);
         tick();
      end
      chk("bp_err", 512'(o_mul_err), 512'd1);
      // rr sits at 2 with only clients 0 and 1 requesting, so the search wraps to 0
      i_mul_rdy = 1'b1;
      #1;
      chk("bp_release_rdy", 512'(o_req_rdy), 512'b001);
      tick();
      chk("bp_next_ctl", 512'(o_mul_ctl), 512'({2'd0, 8'hA5}));
      chk("bp_next_dat", o_mul_dat, {256'd3, 256'd2});

      // Drain with no requests
      i_req_val = 3'b000;
      tick();
      chk("drain_val", 512'(o_mul_val), 512'd0);

      // Response routing
      i_res_val = 1'b1;
      i_res_dat = 256'd20;
      i_res_ctl = {2'd1, 8'h3C};
      i_res_err = 1'b1;
      #1;
      chk("route1_val", 512'(o_res_val), 512'b010);
      chk("route1_rdy", 512'(o_res_rdy), 512'd1);
      chk("route1_dat", 512'(o_res_dat), 512'd20);
      chk("route1_ctl", 512'(o_res_ctl), 512'h3C);
      chk("route1_err", 512'(o_res_err), 512'd1);
      i_res_rdy = 3'b101;
      #1;
      chk("route1_stall", 512'(o_res_rdy), 512'd0);
      chk("route1_stall_val", 512'(o_res_val), 512'b010);
      i_res_dat = 256'd6;
      i_res_ctl = {2'd0, 8'hA5};
      i_res_err = 1'b0;
      #1;
      chk("route0_val", 512'(o_res_val), 512'b001);
      chk("route0_rdy", 512'(o_res_rdy), 512'd1);
      chk("route0_ctl", 512'(o_res_ctl), 512'hA5);
      i_res_val = 1'b0;
      #1;
      chk("route_idle", 512'(o_res_val), 512'd0);
      tick();
      chk("route_no_err", 512'(o_err), 512'd0);

      // Bad tag
      i_res_rdy = 3'b000;
      i_res_ctl = {2'd3, 8'h00};
      i_res_val = 1'b1;
      #1;
      chk("bad_val", 512'(o_res_val), 512'd0);
      chk("bad_rdy", 512'(o_res_rdy), 512'd1);
      chk("bad_err_pre", 512'(o_err), 512'd0);
      tick();
      chk("bad_err", 512'(o_err), 512'd1);
      i_res_val = 1'b0;
      repeat (3) tick();
      chk("bad_err_sticky", 512'(o_err), 512'd1);

      // Reset while a word is stalled
      i_req_val = 3'b100;
      tick();
      i_req_val = 3'b000;
      i_mul_rdy = 1'b0;
      tick();
      chk("mrst_pre_val", 512'(o_mul_val), 512'd1);
      chk("mrst_pre_ctl", 512'(o_mul_ctl), 512'({2'd2, 8'h12}));
      i_rst = 1'b0;
      tick();
      chk("mrst_val", 512'(o_mul_val), 512'd0);
      chk("mrst_err", 512'(o_err), 512'd0);
      chk("mrst_ctl", 512'(o_mul_ctl), 512'd0);
      i_rst     = 1'b1;
      i_req_val = 3'b111;
      i_mul_rdy = 1'b1;
      #1;
      chk("mrst_first_gnt", 512'(o_req_rdy), 512'b001);
      tick();
      chk("mrst_first_ctl", 512'(o_mul_ctl), 512'({2'd0, 8'hA5}));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/secp256k1_mult_arb.md
# secp256k1_mult_arb

Responder-side arbiter for the shared `secp256k1_mult_mod` request/response interface. It lets NUM_IN independent initiators (point_dbl, point_add and similar sequencers) share one modular multiplier:
- Requests are round-robin arbitrated and tagged with the client index in extra ctl bits.
- Multiplier results are routed back to the issuing client by that tag, so each client sees a private multiplier.
- Sits between the point-arithmetic blocks and a single `secp256k1_mult_mod` instance built with CTL_BITS+IDX_BITS ctl width.

## Interface
Parameters:
- NUM_IN, 2: number of client initiators (2..8).
- CTL_BITS, 8: client ctl width; passed through untouched.
- IDX_BITS, $clog2(NUM_IN) (min 1): tag width appended above client ctl.

Ports (one clock; reset is synchronous and active-low):
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous active-low reset; block held in reset while i_rst==0.
- i_req_dat  in  NUM_IN*512  per-client operands; client i at [i*512 +: 512], a=[255:0], b=[511:256].
- i_req_ctl  in  NUM_IN*CTL_BITS  per-client ctl.
- i_req_err  in  NUM_IN  per-client err.
- i_req_val  in  NUM_IN  per-client request valid.
- o_req_rdy  out  NUM_IN  per-client request ready.
- o_mul_dat  out  512  operands to multiplier.
- o_mul_ctl  out  CTL_BITS+IDX_BITS  {client index, client ctl}.
- o_mul_err  out  1  err to multiplier.
- o_mul_val  out  1  request valid to multiplier.
- i_mul_rdy  in  1  multiplier ready.
- i_res_dat  in  256  multiplier result.
- i_res_ctl  in  CTL_BITS+IDX_BITS  returned tag+ctl.
- i_res_err  in  1  result err.
- i_res_val  in  1  result valid.
- o_res_rdy  out  1  result ready to multiplier.
- o_res_dat  out  256  result, broadcast to all clients.
- o_res_ctl  out  CTL_BITS  i_res_ctl[CTL_BITS-1:0].
- o_res_err  out  1  i_res_err.
- o_res_val  out  NUM_IN  one-hot per-client result valid.
- i_res_rdy  in  NUM_IN  per-client result ready.
- o_err  out  1  sticky: result arrived with tag >= NUM_IN.

## Operation
- Request path: one output register stage (o_mul_*). `load = !o_mul_val || i_mul_rdy`.
- Grant: combinational round-robin over i_req_val, starting search at pointer `rr`, wrapping at NUM_IN-1 -> 0.
- o_req_rdy[g] = load && i_req_val[g] for the granted g only; all other bits 0.
  - o_req_rdy never depends on a client's own i_req_val except through grant selection.
- On acceptance of client g: o_mul_dat/err <= client g fields; o_mul_ctl <= {g, ctl_g}; o_mul_val <= 1; rr <= (g+1) mod NUM_IN.
- If load is high and no request is present: o_mul_val <= 0; rr is unchanged.
- Requests are single-beat. No reordering or buffering beyond the one register.
- Response path (combinational, zero latency), with t = i_res_ctl[CTL_BITS +: IDX_BITS]:
  - t < NUM_IN: o_res_val = i_res_val << t; o_res_rdy = i_res_rdy[t]. Client backpressure stalls the multiplier.
  - t >= NUM_IN: response is dropped. o_res_rdy = 1, o_res_val = 0, o_err <= 1 on i_res_val. o_err clears only on reset.

## Timing
- Reset (i_rst==0 at a clock edge): o_mul_val=0, o_mul_dat=0, o_mul_ctl=0, o_mul_err=0, rr=0, o_err=0.
- During reset:
  - o_req_rdy=0, o_res_rdy=0, o_res_val=0.
  - An in-flight o_mul_val is cleared. Clients must reissue after reset.
- Request latency: accepted at edge N -> o_mul_val high from N+1. Sustained 1 request/cycle when i_mul_rdy stays high.
- Stall: while o_mul_val && !i_mul_rdy, o_mul_* hold stable and all o_req_rdy=0.
- Simultaneous drain and accept (o_mul_val && i_mul_rdy && request present): new word loaded the same edge, no bubble.
- Simultaneous request from all clients: grants issued in order rr, rr+1, ...; each client is served at most once per NUM_IN grants.
- A request and a response to the same client in the same cycle are independent; both paths proceed.

## Test plan
- Reset: hold i_rst=0 for 3 cycles with all i_req_val=1 -> o_mul_val=0, o_req_rdy=0, o_err=0. After release, first grant is client 0.
- Fairness: NUM_IN=3, all clients assert continuously, i_mul_rdy=1 -> o_mul_ctl tags 0,1,2,0,1,2 on consecutive cycles, o_mul_val held high.
- Backpressure: client 1 sends a=5, b=7, ctl=8'h3C; i_mul_rdy=0 for 4 cycles -> o_mul_dat/ctl={2'd1,8'h3C} held stable and o_req_rdy=0 throughout. Transfer completes on the first i_mul_rdy=1 cycle.
- Routing: with the real `secp256k1_mult_mod` attached, client 0 sends a=2, b=3 and client 1 sends a=4, b=5. Client 0 gets o_res_dat=6, client 1 gets 20, each with its own ctl. Holding i_res_rdy[1]=0 stalls the multiplier output.
- Bad tag: NUM_IN=3, inject i_res_val with tag 3 -> o_res_val=0, o_res_rdy=1, o_err=1 next cycle and sticky until reset.
- Reset mid-operation: assert i_rst=0 while o_mul_val=1 and i_mul_rdy=0 -> o_mul_val=0 after the edge, rr=0, o_err=0.
